// File: rtl/aes_ahb_pkg.sv
// Shared types and constants for the AES accelerator AHB-Lite master.
package aes_ahb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    DATA  = 2'd2,
    ERROR = 2'd3
  } ahb_state_e;

  localparam int unsigned WORDS_PER_BLOCK = 4;
  localparam int unsigned BYTES_PER_WORD  = 4;

endpackage

// File: rtl/ahb_block_counter.sv
// Word/byte counting for completed transfers; raises end_block on the last
// word of an AES block or of a sized message.
module ahb_block_counter
  import aes_ahb_pkg::*;
#(
  parameter int unsigned WORDS_PER_BLOCK = aes_ahb_pkg::WORDS_PER_BLOCK,
  localparam int unsigned CW = $clog2(WORDS_PER_BLOCK + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        word_done_i,
  input  logic [31:0] size_i,
  output logic        end_block_o
);

  logic [CW-1:0] word_q, word_d, word_inc;
  logic [31:0]   byte_q, byte_d, byte_inc;
  logic          eb_q, eb_d;
  logic          blk_full, size_hit;

  assign word_inc = word_q + CW'(1);
  assign byte_inc = byte_q + 32'(BYTES_PER_WORD);
  assign blk_full = (word_inc == CW'(WORDS_PER_BLOCK));
  assign size_hit = (size_i != 32'd0) && (byte_inc >= size_i);

  always_comb begin
    word_d = word_q;
    byte_d = byte_q;
    eb_d   = 1'b0;
    if (word_done_i) begin
      eb_d = blk_full || size_hit;
      // Reaching the message length restarts both counts for the next message.
      if (size_hit) begin
        word_d = '0;
        byte_d = '0;
      end else begin
        word_d = blk_full ? '0 : word_inc;
        byte_d = byte_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      byte_q <= '0;
      eb_q   <= 1'b0;
    end else begin
      word_q <= word_d;
      byte_q <= byte_d;
      eb_q   <= eb_d;
    end
  end

  assign end_block_o = eb_q;

endmodule

// File: rtl/ahb_master_q.sv
// Single-beat AHB-Lite master: one enable pulse runs one 32-bit read or write.
// Handshake: a phase advances only on a posedge where hready=1; hresp=1 in DATA aborts to ERROR.
module ahb_master_q
  import aes_ahb_pkg::*;
#(
  parameter int unsigned WORDS_PER_BLOCK = aes_ahb_pkg::WORDS_PER_BLOCK
) (
  input  logic        hclk,
  input  logic        hrst,
  input  logic        hready,
  input  logic        hresp,
  input  logic        ahbMode,
  input  logic        enable,
  input  logic [31:0] hrdata,
  input  logic [31:0] shiftin,
  input  logic [31:0] size,
  input  logic [31:0] raddr,
  input  logic [31:0] waddr,
  output logic [31:0] haddr,
  output logic [31:0] hwdata,
  output logic        hwrite,
  output logic [31:0] shiftout,
  output logic        shift_en,
  output logic        end_block,
  output ahb_state_e  dbg_state
);

  ahb_state_e  state_q, state_d;
  logic        mode_q, mode_d;
  logic [31:0] data_q, data_d;
  logic [31:0] haddr_q, haddr_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic        hwrite_q, hwrite_d;
  logic [31:0] shiftout_q, shiftout_d;
  logic        shift_en_q, shift_en_d;
  logic        word_done;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    data_d     = data_q;
    haddr_d    = haddr_q;
    hwdata_d   = hwdata_q;
    hwrite_d   = hwrite_q;
    shiftout_d = shiftout_q;
    shift_en_d = 1'b0;
    word_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          mode_d   = ahbMode;
          data_d   = shiftin;
          haddr_d  = ahbMode ? waddr : raddr;
          hwrite_d = ahbMode;
          state_d  = ADDR;
        end
      end
      ADDR: begin
        if (hready) begin
          if (mode_q) hwdata_d = data_q;
          state_d = DATA;
        end
      end
      DATA: begin
        if (hresp) begin
          hwrite_d = 1'b0;
          state_d  = ERROR;
        end else if (hready) begin
          if (!mode_q) shiftout_d = hrdata;
          shift_en_d = 1'b1;
          word_done  = 1'b1;
          state_d    = IDLE;
        end
      end
      ERROR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hrst) begin
    if (!hrst) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      data_q     <= '0;
      haddr_q    <= '0;
      hwdata_q   <= '0;
      hwrite_q   <= 1'b0;
      shiftout_q <= '0;
      shift_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      data_q     <= data_d;
      haddr_q    <= haddr_d;
      hwdata_q   <= hwdata_d;
      hwrite_q   <= hwrite_d;
      shiftout_q <= shiftout_d;
      shift_en_q <= shift_en_d;
    end
  end

  ahb_block_counter #(.WORDS_PER_BLOCK(WORDS_PER_BLOCK)) u_cnt (
    .clk         (hclk),
    .rst_n       (hrst),
    .word_done_i (word_done),
    .size_i      (size),
    .end_block_o (end_block)
  );

  assign haddr     = haddr_q;
  assign hwdata    = hwdata_q;
  assign hwrite    = hwrite_q;
  assign shiftout  = shiftout_q;
  assign shift_en  = shift_en_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ahb_master_q.sv
// Directed bench for ahb_master_q: reads, writes, wait states, errors, sized messages, async reset.
module tb_ahb_master_q;
  import aes_ahb_pkg::*;

  logic        hclk = 1'b0;
  logic        hrst = 1'b0;
  logic        hready = 1'b1, hresp = 1'b0, ahbMode = 1'b0, enable = 1'b0;
  logic [31:0] hrdata = '0, shiftin = '0, size = '0, raddr = '0, waddr = '0;
  logic [31:0] haddr, hwdata, shiftout;
  logic        hwrite, shift_en, end_block;
  ahb_state_e  dbg_state;

  int checks = 0;
  int errors = 0;

  ahb_master_q dut (
    .hclk(hclk), .hrst(hrst), .hready(hready), .hresp(hresp),
    .ahbMode(ahbMode), .enable(enable), .hrdata(hrdata), .shiftin(shiftin),
    .size(size), .raddr(raddr), .waddr(waddr), .haddr(haddr), .hwdata(hwdata),
    .hwrite(hwrite), .shiftout(shiftout), .shift_en(shift_en),
    .end_block(end_block), .dbg_state(dbg_state)
  );

  always #5 hclk = ~hclk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge hclk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_haddr"},    haddr,             32'd0);
    chk({tag, "_hwdata"},   hwdata,            32'd0);
    chk({tag, "_hwrite"},   32'(hwrite),       32'd0);
    chk({tag, "_shiftout"}, shiftout,          32'd0);
    chk({tag, "_shift_en"}, 32'(shift_en),     32'd0);
    chk({tag, "_endblk"},   32'(end_block),    32'd0);
    chk({tag, "_state"},    32'(dbg_state),    32'(IDLE));
  endtask

  task automatic pulse_reset(input string tag);
    hrst = 1'b0;
    #1;
    chk_zero(tag);
    tick;
    hrst = 1'b1;
  endtask

  // One transfer; ws = hready-low cycles in DATA, during which enable is
  // also raised to confirm it is ignored outside IDLE.
  task automatic xfer(input string tag, input logic mode, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata, input int ws,
                      input logic exp_eb, input logic [31:0] exp_so);
    ahbMode = mode;
    raddr   = mode ? ~addr : addr;
    waddr   = mode ? addr : ~addr;
    shiftin = wdata;
    hrdata  = rdata;
    hready  = 1'b1;
    hresp   = 1'b0;
    enable  = 1'b1;
    tick;
    enable  = 1'b0;
    ahbMode = ~mode;
    raddr   = $urandom_range(32'hffff, 0);
    waddr   = $urandom_range(32'hffff, 0);
    shiftin = $urandom_range(32'hffff, 0);
    chk({tag, "_addr_state"}, 32'(dbg_state), 32'(ADDR));
    chk({tag, "_addr_haddr"}, haddr, addr);
    chk({tag, "_addr_hwrite"}, 32'(hwrite), 32'(mode));
    tick;
    chk({tag, "_data_state"}, 32'(dbg_state), 32'(DATA));
    chk({tag, "_data_haddr"}, haddr, addr);
    chk({tag, "_data_hwrite"}, 32'(hwrite), 32'(mode));
    if (mode) chk({tag, "_data_hwdata"}, hwdata, wdata);
    if (ws > 0) begin
      hready = 1'b0;
      enable = 1'b1;
    end
    for (int i = 0; i < ws; i++) begin
      tick;
      chk({tag, "_wait_state"}, 32'(dbg_state), 32'(DATA));
      chk({tag, "_wait_haddr"}, haddr, addr);
      chk({tag, "_wait_shift_en"}, 32'(shift_en), 32'd0);
      if (mode) chk({tag, "_wait_hwdata"}, hwdata, wdata);
      if (i == ws - 1) begin
        hready = 1'b1;
        enable = 1'b0;
      end
    end
    tick;
    chk({tag, "_done_shift_en"}, 32'(shift_en), 32'd1);
    chk({tag, "_done_endblk"}, 32'(end_block), 32'(exp_eb));
    chk({tag, "_done_shiftout"}, shiftout, exp_so);
    chk({tag, "_done_state"}, 32'(dbg_state), 32'(IDLE));
    tick;
    chk({tag, "_post_shift_en"}, 32'(shift_en), 32'd0);
    chk({tag, "_post_endblk"}, 32'(end_block), 32'd0);
  endtask

  initial begin
    tick;
    tick;
    chk_zero("reset");
    hrst = 1'b1;
    tick;

    // Zero-wait read.
    xfer("rd0", 1'b0, 32'h4, 32'h0, 32'habcd52c2, 0, 1'b0, 32'habcd52c2);

    // Full block of four reads, end_block on the fourth only.
    pulse_reset("rst1");
    xfer("blk0", 1'b0, 32'h0, 32'h0, 32'h3243f6a8, 0, 1'b0, 32'h3243f6a8);
    xfer("blk1", 1'b0, 32'h4, 32'h0, 32'h885a308d, 0, 1'b0, 32'h885a308d);
    xfer("blk2", 1'b0, 32'h8, 32'h0, 32'h313198a2, 0, 1'b0, 32'h313198a2);
    xfer("blk3", 1'b0, 32'hc, 32'h0, 32'he0370734, 0, 1'b1, 32'he0370734);

    // Write, then wait-stated read and write; block count wrapped to 0 above.
    xfer("wr0", 1'b1, 32'h005b8d80, 32'h00112233, 32'h0, 0, 1'b0, 32'he0370734);
    xfer("rdws", 1'b0, 32'h10, 32'h0, 32'h11111111, 2, 1'b0, 32'h11111111);
    xfer("wrws", 1'b1, 32'h20, 32'hcafef00d, 32'h0, 2, 1'b0, 32'h11111111);
    xfer("wrap", 1'b0, 32'h24, 32'h0, 32'h5a5a5a5a, 0, 1'b1, 32'h5a5a5a5a);

    // Error response on a write leaves counters and shiftout untouched.
    pulse_reset("rst2");
    ahbMode = 1'b1;
    waddr   = 32'h40;
    shiftin = 32'h77;
    enable  = 1'b1;
    tick;
    enable  = 1'b0;
    chk("err_addr_hwrite", 32'(hwrite), 32'd1);
    tick;
    chk("err_data_hwdata", hwdata, 32'h77);
    hresp = 1'b1;
    tick;
    chk("err_state", 32'(dbg_state), 32'(ERROR));
    chk("err_hwrite", 32'(hwrite), 32'd0);
    chk("err_shift_en", 32'(shift_en), 32'd0);
    chk("err_haddr", haddr, 32'h40);
    hresp = 1'b0;
    tick;
    chk("err_idle_state", 32'(dbg_state), 32'(IDLE));
    chk("err_idle_shift_en", 32'(shift_en), 32'd0);
    chk("err_idle_shiftout", shiftout, 32'd0);
    chk("err_idle_hwrite", 32'(hwrite), 32'd0);
    xfer("eblk0", 1'b0, 32'h0, 32'h0, 32'h01010101, 0, 1'b0, 32'h01010101);
    xfer("eblk1", 1'b0, 32'h4, 32'h0, 32'h02020202, 0, 1'b0, 32'h02020202);
    xfer("eblk2", 1'b0, 32'h8, 32'h0, 32'h03030303, 0, 1'b0, 32'h03030303);
    xfer("eblk3", 1'b0, 32'hc, 32'h0, 32'h04040404, 0, 1'b1, 32'h04040404);

    // Sized message of 8 bytes: end_block on every second word.
    pulse_reset("rst3");
    size = 32'd8;
    xfer("sz0", 1'b0, 32'h100, 32'h0, 32'haaaa0001, 0, 1'b0, 32'haaaa0001);
    xfer("sz1", 1'b0, 32'h104, 32'h0, 32'haaaa0002, 0, 1'b1, 32'haaaa0002);
    xfer("sz2", 1'b0, 32'h108, 32'h0, 32'haaaa0003, 0, 1'b0, 32'haaaa0003);
    xfer("sz3", 1'b0, 32'h10c, 32'h0, 32'haaaa0004, 0, 1'b1, 32'haaaa0004);
    size = 32'd0;

    // Async reset while a write sits in DATA.
    ahbMode = 1'b1;
    waddr   = 32'h200;
    shiftin = 32'h12345678;
    enable  = 1'b1;
    tick;
    enable  = 1'b0;
    tick;
    chk("arst_pre_state", 32'(dbg_state), 32'(DATA));
    chk("arst_pre_hwrite", 32'(hwrite), 32'd1);
    hrst = 1'b0;
    #1;
    chk_zero("arst");
    tick;
    hrst = 1'b1;
    tick;
    chk("arst_post_state", 32'(dbg_state), 32'(IDLE));
    chk("arst_post_shift_en", 32'(shift_en), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
